score_display_scan: RTL and testbench

Display stage that consumes the 8-bit count `Q` produced by the up/down score counter and drives a 4-digit common-anode seven-segment display. It converts the binary value to three BCD digits with a sequential shift-add-3 (double-dabble) engine, then time-multiplexes the digits onto shared segment lines. The display is always coherent: the shown digits change only after a complete conversion.

---
 rtl/score_display_scan.sv | 166 ++++++++++++++++
 tb/tb_score_display_scan.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/score_display_scan.sv
// score_display_scan: converts an 8-bit binary value to three BCD digits with
// a sequential double-dabble engine and scans them onto a common-anode
// 4-digit seven-segment display (SEG/AN active-low, AN[3] unused).
// Optional build macro: LEADING_ZERO_BLANK_EN, which suppresses leading zeros
// on the hundreds and tens digits.
module score_display_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [7:0] VALUE,
    input  logic       BLANK,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic       BUSY
);
    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t         state_q, state_d;
    logic [7:0]     last_q, last_d;
    logic [7:0]     shift_q, shift_d;
    logic [11:0]    work_q, work_d;
    logic [2:0]     bit_q, bit_d;
    logic [3:0]     d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic           busy_q, busy_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [1:0]     sel_q, sel_d;
    logic [6:0]     seg_q, seg_d;
    logic [3:0]     an_q, an_d;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift
    function automatic logic [11:0] dabble(input logic [11:0] w);
        logic [11:0] r;
        r = w;
        for (int i = 0; i < 3; i++)
            if (w[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    // Active-low {g..a}; anything above 9 cannot come out of the converter
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    // Converter next state: capture on change, 8 dabble/shift steps, publish
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shift_d = shift_q;
        work_d  = work_q;
        bit_d   = bit_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        case (state_q)
            IDLE: begin
                if (VALUE != last_q) begin
                    shift_d = VALUE;
                    last_d  = VALUE;
                    work_d  = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {work_d, shift_d} = {dabble(work_q), shift_q} << 1;
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = UPDATE;
            end
            UPDATE: begin
                d2_d    = work_q[11:8];
                d1_d    = work_q[7:4];
                d0_d    = work_q[3:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Held one extra cycle past UPDATE so it drops only once the new
        // digits can already be on the segment register.
        busy_d = (state_d != IDLE) || (state_q == UPDATE);
    end

    // Scan timing and registered segment/anode drive
    always_comb begin
        logic [3:0] dig;
        logic [6:0] seg_raw;
        tick_d = tick_q + TW'(1);
        sel_d  = sel_q;
        if (tick_q == TW'(SCAN_DIV - 1)) begin
            tick_d = '0;
            sel_d  = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
        end
        case (sel_q)
            2'd1:    dig = d1_q;
            2'd2:    dig = d2_q;
            default: dig = d0_q;
        endcase
        seg_raw = decode(dig);
`ifdef LEADING_ZERO_BLANK_EN
        if (sel_q == 2'd2 && d2_q == 4'd0) seg_raw = 7'h7F;
        if (sel_q == 2'd1 && d2_q == 4'd0 && d1_q == 4'd0) seg_raw = 7'h7F;
`endif
        case (sel_q)
            2'd1:    an_d = 4'b1101;
            2'd2:    an_d = 4'b1011;
            default: an_d = 4'b1110;
        endcase
        seg_d = seg_raw;
        if (BLANK) begin
            seg_d = 7'h7F;
            an_d  = 4'hF;
        end
    end

    // State registers; CLR abandons any conversion in flight
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= IDLE;
            last_q  <= '0;
            shift_q <= '0;
            work_q  <= '0;
            bit_q   <= '0;
            d2_q    <= '0;
            d1_q    <= '0;
            d0_q    <= '0;
            busy_q  <= 1'b0;
            tick_q  <= '0;
            sel_q   <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            bit_q   <= bit_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign SEG  = seg_q;
    assign AN   = an_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_score_display_scan.sv
// Bench for score_display_scan: directed scenarios plus random traffic, every
// output checked each cycle against a cycle-level model built from decimal
// arithmetic on the displayed value.
module tb_score_display_scan;
    localparam int SD = 4;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [7:0] VALUE;
    logic       BLANK;
    logic [6:0] SEG;
    logic [3:0] AN;
    logic       BUSY;

    int n_chk = 0;
    int n_err = 0;

    score_display_scan #(.SCAN_DIV(SD)) dut (
        .CLK(CLK), .CLR(CLR), .VALUE(VALUE), .BLANK(BLANK),
        .SEG(SEG), .AN(AN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [6:0]  seg_tab [10];
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_busy;
    int unsigned n_m, cnt_m, dval_m, pend_m;
    logic [7:0]  last_m;

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    end

    // Model steps on each rising edge from the inputs present at that edge;
    // cnt_m counts down the 10 busy cycles of a conversion, and a value of
    // 1 marks the cycle where the converter is back to watching VALUE.
    always @(posedge CLK) begin
        int unsigned sel, dig;
        logic [6:0] sg;
        if (CLR) begin
            exp_seg = 7'h7F; exp_an = 4'hF; exp_busy = 1'b0;
            dval_m = 0; last_m = 8'd0; cnt_m = 0; n_m = 0;
        end else begin
            sel = (n_m / SD) % 3;
            n_m++;
            dig = (sel == 0) ? dval_m % 10 : (sel == 1) ? (dval_m / 10) % 10 : dval_m / 100;
            sg = seg_tab[dig];
`ifdef LEADING_ZERO_BLANK_EN
            if (sel == 2 && dval_m < 100) sg = 7'h7F;
            if (sel == 1 && dval_m < 10)  sg = 7'h7F;
`endif
            if (BLANK) begin
                exp_seg = 7'h7F; exp_an = 4'hF;
            end else begin
                exp_seg = sg; exp_an = 4'hF & ~(4'b0001 << sel);
            end
            if (cnt_m <= 1) begin
                if (VALUE != last_m) begin
                    last_m = VALUE; pend_m = VALUE; cnt_m = 10;
                end else cnt_m = 0;
            end else begin
                cnt_m--;
                if (cnt_m == 1) dval_m = pend_m;
            end
            exp_busy = (cnt_m != 0);
        end
    end

    // Compare every cycle, half a period after the edge
    always @(negedge CLK) begin
        chk("SEG", SEG, exp_seg);
        chk("AN", AN, exp_an);
        chk("BUSY", BUSY, exp_busy);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int busy_len;
        CLR = 1'b1; VALUE = 8'd0; BLANK = 1'b0;
        // Reset, then VALUE=0 must not start a conversion
        cyc(3);
        CLR = 1'b0;
        cyc(30);
        // Value 8: BUSY high for exactly 10 cycles
        VALUE = 8'd8;
        busy_len = 0;
        for (int i = 0; i < 25; i++) begin
            cyc(1);
            if (BUSY) busy_len++;
        end
        chk("busy_len", busy_len, 10);
        cyc(15);
        // Value 255
        VALUE = 8'd255;
        cyc(30);
        // Mid-conversion change: 9 then 123 a few cycles into SHIFT
        VALUE = 8'd9;
        cyc(4);
        VALUE = 8'd123;
        cyc(40);
        // Reset during SHIFT with VALUE=200 held
        VALUE = 8'd200;
        cyc(3);
        CLR = 1'b1;
        cyc(1);
        CLR = 1'b0;
        cyc(30);
        // Blank mid-frame
        cyc(2);
        BLANK = 1'b1;
        cyc(5);
        BLANK = 1'b0;
        cyc(20);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) VALUE = 8'($urandom_range(0, 255));
            BLANK = ($urandom_range(0, 9) == 0);
            CLR   = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        CLR = 1'b0; BLANK = 1'b0;
        cyc(30);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
